// File: rtl/pipelined_shifter_if.sv
// Valid/ready bus for pipelined_shifter.
// Optional SHIFTER_FLAGS_EN adds the out_carry/out_zero result flags.
interface pipelined_shifter_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
`ifdef SHIFTER_FLAGS_EN
    logic               out_carry;
    logic               out_zero;
`endif

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
`ifdef SHIFTER_FLAGS_EN
        , input out_carry, out_zero
`endif
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
`ifdef SHIFTER_FLAGS_EN
        , output out_carry, out_zero
`endif
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR), one register stage per shift-amount bit,
// valid/ready on both sides with a global stall. Optional SHIFTER_FLAGS_EN adds carry/zero flags.
module pipelined_shifter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                reset,
    pipelined_shifter_if.slave bus
);
    localparam int unsigned LAST     = SHAMT_W - 1;
    localparam logic [1:0]  MODE_LSL = 2'b00;
    localparam logic [1:0]  MODE_LSR = 2'b01;
    localparam logic [1:0]  MODE_ASR = 2'b10;

    logic               advance;
    logic [WIDTH-1:0]   src_data [SHAMT_W];
    logic [SHAMT_W-1:0] src_rem  [SHAMT_W];
    logic [1:0]         src_mode [SHAMT_W];
    logic [SHAMT_W-1:0] src_valid;
    logic [WIDTH-1:0]   nxt_data [SHAMT_W];

    logic [WIDTH-1:0]   data_q   [SHAMT_W];
    logic [SHAMT_W-1:0] rem_q    [SHAMT_W];
    logic [1:0]         mode_q   [SHAMT_W];
    logic [SHAMT_W-1:0] valid_q;
`ifdef SHIFTER_FLAGS_EN
    logic [SHAMT_W-1:0] src_carry;
    logic [SHAMT_W-1:0] nxt_carry;
    logic [SHAMT_W-1:0] carry_q;
    logic               zero_q;
`endif

    // One level of the barrel: shift by a fixed power-of-two step.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       mode,
                                                     input int unsigned      step);
        case (mode)
            MODE_LSL: return d << step;
            MODE_LSR: return d >> step;
            MODE_ASR: return WIDTH'($signed(d) >>> step);
            default:  return (d >> step) | (d << (WIDTH - step));
        endcase
    endfunction

`ifdef SHIFTER_FLAGS_EN
    // Last bit leaving the word at this level; for ROR it is the bit landing in the MSB.
    function automatic logic shifted_out(input logic [WIDTH-1:0] d,
                                         input logic [1:0]       mode,
                                         input int unsigned      step);
        if (mode == MODE_LSL) return d[SHAMT_W'(WIDTH - step)];
        return d[SHAMT_W'(step - 1)];
    endfunction
`endif

    // A full output stage that is not being drained freezes the whole pipe.
    assign advance       = !valid_q[LAST] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
`ifdef SHIFTER_FLAGS_EN
    assign bus.out_carry = carry_q[LAST];
    assign bus.out_zero  = zero_q;
`endif

    // Stage inputs and next-state for every level.
    always_comb begin
        src_data[0]  = bus.in_data;
        src_rem[0]   = bus.in_shamt;
        src_mode[0]  = bus.in_mode;
        src_valid[0] = bus.in_valid;
        for (int k = 1; k < SHAMT_W; k++) begin
            src_data[k]  = data_q[k-1];
            src_rem[k]   = rem_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
`ifdef SHIFTER_FLAGS_EN
        src_carry[0] = 1'b0;
        for (int k = 1; k < SHAMT_W; k++) begin
            src_carry[k] = carry_q[k-1];
        end
`endif
        for (int k = 0; k < SHAMT_W; k++) begin
            nxt_data[k] = src_rem[k][0] ? shift_level(src_data[k], src_mode[k], 32'd1 << k)
                                        : src_data[k];
`ifdef SHIFTER_FLAGS_EN
            nxt_carry[k] = src_rem[k][0] ? shifted_out(src_data[k], src_mode[k], 32'd1 << k)
                                         : src_carry[k];
`endif
        end
    end

    // Remaining shift amount is shifted down so each stage always tests bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k] <= '0;
                rem_q[k]  <= '0;
                mode_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k] <= nxt_data[k];
                rem_q[k]  <= src_rem[k] >> 1;
                mode_q[k] <= src_mode[k];
            end
            valid_q <= src_valid;
        end
    end

`ifdef SHIFTER_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= '0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            carry_q <= nxt_carry;
            zero_q  <= (nxt_data[LAST] == '0);
        end
    end
`endif
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=16): reset, modes, stall/back-to-back,
// reset flush and a randomised stream against a reference shifter.
module tb_pipelined_shifter;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned SHAMT_W = 4;
    localparam int          LAT     = 4;
    localparam int          NVEC    = 16;
    localparam int          NSTREAM = 6;
    localparam int          NRAND   = 400;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  s;
        logic [1:0]  m;
        logic [15:0] exp;
        logic        c;
        logic        z;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_t vecs [NVEC] = '{
        '{16'h0001, 4'd15, 2'd0, 16'h8000, 1'b0, 1'b0},
        '{16'h8000, 4'd4,  2'd2, 16'hF800, 1'b0, 1'b0},
        '{16'h8000, 4'd4,  2'd1, 16'h0800, 1'b0, 1'b0},
        '{16'h1234, 4'd4,  2'd3, 16'h4123, 1'b0, 1'b0},
        '{16'hBEEF, 4'd0,  2'd0, 16'hBEEF, 1'b0, 1'b0},
        '{16'hBEEF, 4'd0,  2'd1, 16'hBEEF, 1'b0, 1'b0},
        '{16'hBEEF, 4'd0,  2'd2, 16'hBEEF, 1'b0, 1'b0},
        '{16'hBEEF, 4'd0,  2'd3, 16'hBEEF, 1'b0, 1'b0},
        '{16'h0018, 4'd4,  2'd1, 16'h0001, 1'b1, 1'b0},
        '{16'h8000, 4'd1,  2'd0, 16'h0000, 1'b1, 1'b1},
        '{16'h0001, 4'd1,  2'd3, 16'h8000, 1'b1, 1'b0},
        '{16'hFFFF, 4'd8,  2'd0, 16'hFF00, 1'b1, 1'b0},
        '{16'h7FF0, 4'd8,  2'd2, 16'h007F, 1'b1, 1'b0},
        '{16'h8001, 4'd15, 2'd2, 16'hFFFF, 1'b0, 1'b0},
        '{16'h8001, 4'd15, 2'd3, 16'h0003, 1'b0, 1'b0},
        '{16'hFFFF, 4'd15, 2'd1, 16'h0001, 1'b1, 1'b0}
    };

    logic [15:0] st_d   [NSTREAM] = '{16'h0003, 16'h00F0, 16'hF000, 16'h000F, 16'h1111, 16'hABCD};
    logic [3:0]  st_s   [NSTREAM] = '{4'd1, 4'd4, 4'd2, 4'd4, 4'd3, 4'd8};
    logic [1:0]  st_m   [NSTREAM] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    logic [15:0] st_exp [NSTREAM] = '{16'h0006, 16'h000F, 16'hFC00, 16'hF000, 16'h8888, 16'hCDAB};

    pipelined_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    pipelined_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                              input logic [1:0] m);
        logic [31:0] dd;
        case (m)
            2'd0:    ref_shift = d << s;
            2'd1:    ref_shift = d >> s;
            2'd2:    ref_shift = 16'($signed(d) >>> s);
            default: begin
                dd        = {d, d} >> s;
                ref_shift = dd[15:0];
            end
        endcase
    endfunction

`ifdef SHIFTER_FLAGS_EN
    function automatic logic ref_carry(input logic [15:0] d, input logic [3:0] s,
                                       input logic [1:0] m);
        logic [15:0] r;
        logic [3:0]  idx;
        if (s == 4'd0) return 1'b0;
        case (m)
            2'd0: begin
                idx = 4'(16 - int'(s));
                return d[idx];
            end
            2'd3: begin
                r = ref_shift(d, s, m);
                return r[15];
            end
            default: begin
                idx = s - 4'd1;
                return d[idx];
            end
        endcase
    endfunction
`endif

    // Drives one op from a negedge with an idle pipe and waits for its result.
    task automatic send_op(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m,
                           output logic [15:0] res, output int lat,
                           output logic c, output logic z);
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) lat = -1;
        res = bus.out_data;
        c   = 1'b0;
        z   = 1'b0;
`ifdef SHIFTER_FLAGS_EN
        c = bus.out_carry;
        z = bus.out_zero;
`endif
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0000", bus.out_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_held: got %b, expected 1", bus.in_ready); end
`ifdef SHIFTER_FLAGS_EN
        n_checks++; if (bus.out_carry !== 1'b0 || bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got c=%b z=%b, expected 0 0", bus.out_carry, bus.out_zero); end
`endif
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release: got %b, expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b, expected 0", bus.out_valid); end
    endtask

    task automatic test_modes();
        logic [15:0] res;
        int          lat;
        logic        c, z;
        for (int i = 0; i < NVEC; i++) begin
            send_op(vecs[i].d, vecs[i].s, vecs[i].m, res, lat, c, z);
            n_checks++; if (res !== vecs[i].exp) begin n_fail++; $display("FAIL mode_data[%0d]: got %h, expected %h", i, res, vecs[i].exp); end
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL mode_latency[%0d]: got %0d, expected %0d", i, lat, LAT); end
`ifdef SHIFTER_FLAGS_EN
            n_checks++; if (c !== vecs[i].c) begin n_fail++; $display("FAIL mode_carry[%0d]: got %b, expected %b", i, c, vecs[i].c); end
            n_checks++; if (z !== vecs[i].z) begin n_fail++; $display("FAIL mode_zero[%0d]: got %b, expected %b", i, z, vecs[i].z); end
`else
            if (c !== 1'b0 || z !== 1'b0) $display("note: flag outputs absent in this build");
`endif
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0, rcv = 0, cyc = 0, stall_left = 0, last_cyc = -1, extra = 0;
        logic        stall_done = 1'b0;
        logic [15:0] held = '0;
        logic [15:0] got [$];
        @(negedge clk);
        while ((sent < NSTREAM || rcv < NSTREAM) && cyc < 60) begin
            if (rcv == 1 && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            bus.out_ready = (stall_left == 0);
            if (sent < NSTREAM) begin
                bus.in_data  = st_d[sent];
                bus.in_shamt = st_s[sent];
                bus.in_mode  = st_m[sent];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.out_ready && bus.out_valid) begin
                n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d: got %b, expected 0", cyc, bus.in_ready); end
                if (stall_left == 3) held = bus.out_data;
                else begin
                    n_checks++; if (bus.out_data !== held) begin n_fail++; $display("FAIL stall_stable cyc %0d: got %h, expected %h", cyc, bus.out_data, held); end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                if (rcv >= 2) begin
                    n_checks++; if (cyc !== last_cyc + 1) begin n_fail++; $display("FAIL stream_throughput: got gap %0d, expected 1", cyc - last_cyc); end
                end
                last_cyc = cyc;
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (cyc >= 60) begin n_fail++; $display("FAIL stream_timeout: got %0d cycles, expected < 60", cyc); end
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) extra++;
            @(negedge clk);
        end
        n_checks++; if (got.size() + extra !== NSTREAM) begin n_fail++; $display("FAIL stream_count: got %0d, expected %0d", got.size() + extra, NSTREAM); end
        for (int i = 0; i < NSTREAM && i < got.size(); i++) begin
            n_checks++; if (got[i] !== st_exp[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h, expected %h", i, got[i], st_exp[i]); end
        end
    endtask

    task automatic test_reset_flush();
        logic [15:0] res;
        int          lat, seen = 0;
        logic        c, z;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = 16'h0001;
            bus.in_shamt = 4'(i + 1);
            bus.in_mode  = 2'd0;
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b, expected 1", bus.out_valid); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_async_valid: got %b, expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL flush_async_data: got %h, expected 0000", bus.out_data); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_ghost_results: got %0d, expected 0", seen); end
        send_op(16'h00F1, 4'd4, 2'd3, res, lat, c, z);
        n_checks++; if (res !== 16'h100F) begin n_fail++; $display("FAIL flush_new_data: got %h, expected 100F", res); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL flush_new_latency: got %0d, expected %0d", lat, LAT); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [17:0] exp_q [$];
        logic [17:0] e;
        logic [15:0] r;
        logic        c;
        int          acc = 0, outs = 0, cyc = 0;
        while ((acc < NRAND || exp_q.size() > 0) && cyc < 20000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (acc < NRAND && $urandom_range(0, 4) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'($urandom);
                bus.in_shamt = 4'($urandom);
                bus.in_mode  = 2'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                outs++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected: got %h, expected no result", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e[15:0]) begin n_fail++; $display("FAIL rand_data #%0d: got %h, expected %h", outs, bus.out_data, e[15:0]); end
`ifdef SHIFTER_FLAGS_EN
                    n_checks++; if ({bus.out_zero, bus.out_carry} !== e[17:16]) begin n_fail++; $display("FAIL rand_flags #%0d: got z,c=%b, expected %b", outs, {bus.out_zero, bus.out_carry}, e[17:16]); end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                r = ref_shift(bus.in_data, bus.in_shamt, bus.in_mode);
                c = 1'b0;
`ifdef SHIFTER_FLAGS_EN
                c = ref_carry(bus.in_data, bus.in_shamt, bus.in_mode);
`endif
                exp_q.push_back({(r == 16'h0000), c, r});
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (cyc >= 20000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles, expected < 20000", cyc); end
        n_checks++; if (outs !== acc) begin n_fail++; $display("FAIL rand_count: got %0d outputs, expected %0d", outs, acc); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
